// File: rtl/prbs_tx_par_pkg.sv
// rtl/prbs_tx_par_pkg.sv - PRBS polynomial table, state encoding and mask helpers
package prbs_pkg;

  localparam int PRBS_W = 31;

  localparam logic [2:0] TYPE_PRBS7  = 3'd0;
  localparam logic [2:0] TYPE_PRBS9  = 3'd1;
  localparam logic [2:0] TYPE_PRBS15 = 3'd2;
  localparam logic [2:0] TYPE_PRBS23 = 3'd3;
  localparam logic [2:0] TYPE_PRBS31 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Active register length and the two 1-based feedback taps
  typedef struct packed {
    logic [4:0] len;
    logic [4:0] tap_a;
    logic [4:0] tap_b;
  } poly_t;

  // Register length per type; unused codes fall back to PRBS7
  function automatic logic [4:0] poly_len(input logic [2:0] ptype);
    logic [4:0] l;
    case (ptype)
      TYPE_PRBS7:  l = 5'd7;
      TYPE_PRBS9:  l = 5'd9;
      TYPE_PRBS15: l = 5'd15;
      TYPE_PRBS23: l = 5'd23;
      TYPE_PRBS31: l = 5'd31;
      default:     l = 5'd7;
    endcase
    return l;
  endfunction

  // Every supported polynomial has its leading tap at x^L, so tap_a equals the length
  function automatic poly_t poly_cfg(input logic [2:0] ptype);
    poly_t p;
    p.len   = poly_len(ptype);
    p.tap_a = p.len;
    case (ptype)
      TYPE_PRBS9:  p.tap_b = 5'd5;
      TYPE_PRBS15: p.tap_b = 5'd14;
      TYPE_PRBS23: p.tap_b = 5'd18;
      TYPE_PRBS31: p.tap_b = 5'd28;
      default:     p.tap_b = 5'd6;
    endcase
    return p;
  endfunction

  // Low `len` bits set; one extra bit of headroom keeps len=31 exact
  function automatic logic [PRBS_W-1:0] len_mask(input logic [4:0] len);
    logic [PRBS_W:0] one;
    logic [PRBS_W:0] m;
    one    = '0;
    one[0] = 1'b1;
    m      = (one << len) - one;
    return m[PRBS_W-1:0];
  endfunction

endpackage

// File: rtl/prbs_tx_par_if.sv
// rtl/prbs_tx_par_if.sv - valid/ready word stream between PRBS source and sink
interface prbs_tx_par_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_rdy;

  modport master (output dout, output dout_vld, input dout_rdy);
  modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/prbs_tx_par_lfsr_step_n.sv
// rtl/prbs_tx_par_lfsr_step_n.sv - combinational N-step Fibonacci LFSR unroll
module prbs_lfsr_step_n
  import prbs_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [PRBS_W-1:0] state_in,
  input  logic [2:0]        ptype,
  output logic [PRBS_W-1:0] state_out,
  output logic [N-1:0]      word
);

  poly_t             cfg;
  logic [PRBS_W-1:0] mask;
  logic [PRBS_W-1:0] s;
  logic              nb;

  // Walk N single steps; each feedback bit is also that step's output, first bit to the MSB
  always_comb begin
    cfg  = poly_cfg(ptype);
    mask = len_mask(cfg.len);
    s    = state_in;
    nb   = 1'b0;
    word = '0;
    for (int i = 0; i < N; i++) begin
      nb          = s[cfg.tap_a - 5'd1] ^ s[cfg.tap_b - 5'd1];
      word[N-1-i] = nb;
      s           = {s[PRBS_W-2:0], nb} & mask;
    end
    state_out = s;
  end

endmodule

// File: rtl/prbs_tx_par.sv
// rtl/prbs_tx_par.sv - run-time selectable PRBS word transmitter with error injection
module prbs_tx_par
  import prbs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prbs_en,
  input  logic [2:0]        prbs_type,
  input  logic [PRBS_W-1:0] seed,
  input  logic              inj_err,
  prbs_tx_par_if.master     tx,
  output logic              busy,
  output logic [31:0]       word_cnt,
  output logic [15:0]       inj_cnt
);

  state_t            state;
  logic              en_q;
  logic [2:0]        ptype_q;
  logic [PRBS_W-1:0] lfsr;
  logic [PRBS_W-1:0] lfsr_nxt;
  logic [PRBS_W-1:0] start_mask;
  logic [PRBS_W-1:0] seed_masked;
  logic [PRBS_W-1:0] seed_ld;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_inj;
  logic              inj_pend;
  logic              en_rise;
  logic              load;
  logic              accept;
  logic              inj_fire;

  prbs_lfsr_step_n #(.N(DATA_W)) u_step (
    .state_in  (lfsr),
    .ptype     (ptype_q),
    .state_out (lfsr_nxt),
    .word      (word)
  );

  // Seed conditioning for the selected length, and MSB flip of the next word when an error is pending
  always_comb begin
    start_mask            = len_mask(poly_len(prbs_type));
    seed_masked           = seed & start_mask;
    seed_ld               = (seed_masked == '0) ? start_mask : seed_masked;
    word_inj              = word;
    word_inj[DATA_W-1]    = word[DATA_W-1] ^ inj_pend;
  end

  assign en_rise  = prbs_en & ~en_q;
  assign accept   = tx.dout_vld & tx.dout_rdy;
  assign load     = (state == ST_RUN) & prbs_en & (~tx.dout_vld | tx.dout_rdy);
  assign inj_fire = load & inj_pend;

  // Run-control FSM together with the LFSR, output register and pending-injection flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      en_q        <= 1'b0;
      ptype_q     <= TYPE_PRBS7;
      lfsr        <= '1;
      inj_pend    <= 1'b0;
      tx.dout     <= '0;
      tx.dout_vld <= 1'b0;
    end else begin
      en_q <= prbs_en;
      case (state)
        ST_IDLE: begin
          if (en_rise) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            ptype_q  <= prbs_type;
            lfsr     <= seed_ld;
            inj_pend <= 1'b0;
          end
        end
        ST_RUN: begin
          if (inj_err) inj_pend <= 1'b1;
          if (prbs_en) begin
            if (load) begin
              tx.dout     <= word_inj;
              tx.dout_vld <= 1'b1;
              lfsr        <= lfsr_nxt;
              // Consuming the flag wins over a same-cycle pulse: that pulse merges into this error
              if (inj_pend) inj_pend <= 1'b0;
            end
          end else if (tx.dout_vld && !tx.dout_rdy) begin
            state <= ST_DRAIN;
          end else begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            tx.dout_vld <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (tx.dout_rdy) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            tx.dout_vld <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          tx.dout_vld <= 1'b0;
        end
      endcase
    end
  end

  // Accepted-word counter (wrapping) and injected-error counter (saturating), cleared at run start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else if (state == ST_IDLE && en_rise) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else begin
      if (accept) word_cnt <= word_cnt + 32'd1;
      if (inj_fire && inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
    end
  end

endmodule

// File: doc/prbs_tx_par.md
# prbs_tx_par

Parametrised PRBS transmitter. It generates PRBS7/9/15/23/31 sequences, with the polynomial selected at run time, and emits `DATA_W` bits per transfer over a valid/ready stream. It also supports a loadable seed, single-bit error injection, and transfer/injection counters. It is the successor to the single-bit, fixed-polynomial PRBS transmitter and feeds serialisers or loopback paths in the PRBS test datapath.

## Interface
- `DATA_W`, 8: bits per output word, legal range 1..32.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous reset, active-low.
- `prbs_en` in 1: run request. A 0→1 transition in IDLE starts a run; dropping it to 0 stops the run.
- `prbs_type` in 3: polynomial select, sampled only at run start.
  - 0 = PRBS7 (x^7+x^6+1)
  - 1 = PRBS9 (x^9+x^5+1)
  - 2 = PRBS15 (x^15+x^14+1)
  - 3 = PRBS23 (x^23+x^18+1)
  - 4 = PRBS31 (x^31+x^28+1)
  - 5..7 map to PRBS7.
- `seed` in 31: LFSR seed, sampled at run start. Bits above the polynomial length are ignored.
- `inj_err` in 1: single-cycle pulse that requests one bit error.
- `dout` out `DATA_W`: output word. The first-generated bit is at `dout[DATA_W-1]`.
- `dout_vld` out 1: word valid.
- `dout_rdy` in 1: downstream ready.
- `busy` out 1: high in RUN and DRAIN.
- `word_cnt` out 32: count of accepted words. It wraps and is cleared at run start.
- `inj_cnt` out 16: count of injected errors. It saturates at 0xFFFF and is cleared at run start.

## Operation
- LFSR is a Fibonacci register `s[30:0]`, with active length L taken from the type.
  - One step: `nb = s[tA-1] ^ s[tB-1]`, then `s <= {s[29:0], nb}` masked to L bits.
  - The output bit of the step is `nb`.
- One word consists of `DATA_W` consecutive steps, computed combinationally from the current state. The first step's bit goes to the MSB.
- Seed handling: the masked seed is used as loaded. If the masked seed is zero, all-ones of length L is used instead.
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on rising `prbs_en`:
    - latch the type;
    - load the seed;
    - clear both counters;
    - clear any pending injection.
  - RUN → DRAIN when `prbs_en`=0 and `dout_vld`=1 and `dout_rdy`=0.
  - RUN → IDLE when `prbs_en`=0 and no word is held, or when the held word is accepted that cycle.
  - DRAIN → IDLE when the held word is accepted.
  - A rising `prbs_en` during DRAIN is ignored. A fresh 0→1 edge is required after IDLE is reached.
- Output register:
  - It loads the next word whenever it is empty or its current word is accepted, while in RUN with `prbs_en`=1.
  - The LFSR advances by `DATA_W` steps on each such load.
- Injection:
  - An `inj_err` pulse sets a pending flag.
  - The next word loaded into the output register has `dout[DATA_W-1]` inverted. The LFSR state is unaffected.
  - The flag then clears and `inj_cnt` increments.
  - Extra pulses while a flag is pending are merged into that one error.
  - `inj_err` is ignored in IDLE and DRAIN.
- `word_cnt` increments on each `dout_vld && dout_rdy`, and wraps from 0xFFFFFFFF to 0.
- `prbs_type` and `seed` changes during RUN or DRAIN have no effect.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `busy`=0, `word_cnt`=0, `inj_cnt`=0, state IDLE, LFSR all-ones.
- First valid word: `dout_vld` rises 2 cycles after the `prbs_en` rising edge is sampled.
  - Cycle 1: seed is loaded.
  - Cycle 2: the word is registered.
- Throughput is one word per cycle while `dout_rdy`=1, with no bubbles.
- Handshake rules:
  - `dout` and `dout_vld` are held stable while `dout_vld`=1 and `dout_rdy`=0.
  - `dout_vld` never drops without a transfer, except on reset.
- Injection latency: a pulse in cycle N is applied to the word loaded in cycle N+1 or later. It is never applied to a word already held.
- Asserting `rst` mid-run clears everything immediately. Any held word is lost.
- All outputs are registered. There is no combinational path from `dout_rdy` to `dout_vld`.

## Structure
- Package `prbs_pkg` holds:
  - type-code constants;
  - length/tap lookup function (type → L, tA, tB);
  - state enum;
  - `PRBS_W` = 31.
- Sub-module `prbs_lfsr_step_n`: a combinational N-step unroll with `N` = `DATA_W`.
  - Inputs: state and type.
  - Outputs: next state and word.
- The top level holds the FSM, the output register, injection and the counters.

## Test plan
- PRBS7, seed all-ones, `DATA_W`=8, `dout_rdy`=1 → first words 0x02, then 0x0C. The sequence repeats after 127 bits.
- PRBS31 with `seed`=0 → behaves identically to an all-ones seed. A reference model matches 10^5 words, and `word_cnt`=100000.
- Random `dout_rdy` backpressure → `dout` stable while stalled, no word dropped or duplicated against the model.
- `inj_err` pulse mid-run → exactly one word differs from the model, only in its MSB. `inj_cnt`=1. Subsequent words match.
- `prbs_en` dropped while stalled → state DRAIN, `busy`=1. The held word is delivered once, then IDLE, `dout_vld`=0.
- `rst` asserted during RUN → all outputs at reset values within the same cycle. After restart, the sequence begins again from the seed.
